// File: rtl/eq_pkg.sv
// Shared widths, gain/saturation constants and sequencer states for the
// equalizer gain sequencer.
package eq_pkg;
  localparam int GAIN_W    = 16;
  localparam int AUDIO_W   = 24;
  localparam int GAIN_FRAC = 14;

  localparam logic [GAIN_W-1:0]         GAIN_UNITY = 16'h4000;
  localparam logic signed [AUDIO_W-1:0] AUDIO_MAX  = 24'sh7FFFFF;
  localparam logic signed [AUDIO_W-1:0] AUDIO_MIN  = 24'sh800000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SAT
  } eq_seq_state_t;
endpackage

// File: rtl/eq_mac.sv
// Single signed 24x16 multiplier feeding two accumulators; ch selects which
// channel's accumulator takes the product.
module eq_mac
  import eq_pkg::*;
#(
  parameter int ACC_W = 42
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      en,
  input  logic                      ch,
  input  logic signed [AUDIO_W-1:0] sample,
  input  logic signed [GAIN_W-1:0]  gain,
  output logic signed [ACC_W-1:0]   acc_l,
  output logic signed [ACC_W-1:0]   acc_r
);

  localparam int PROD_W = AUDIO_W + GAIN_W;

  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  product_ext;

  assign product     = sample * gain;
  assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (en) begin
      if (ch) begin
        acc_r <= acc_r + product_ext;
      end else begin
        acc_l <= acc_l + product_ext;
      end
    end
  end

endmodule

// File: rtl/eq_gain_sequencer.sv
// Per-band gain and band summation for both channels, using one shared MAC
// sequenced L0,R0,L1,R1,... once per audio sample.
module eq_gain_sequencer
  import eq_pkg::*;
#(
  parameter int num_of_filters = 4,
  parameter int GAIN_FRAC      = eq_pkg::GAIN_FRAC
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        eq_wr,
  input  logic [num_of_filters-1:0]   eq_wr_sel,
  input  logic [15:0]                 eq_gain,
  input  logic                        sample_en,
  input  logic [48*num_of_filters-1:0] l_data_in,
  input  logic [48*num_of_filters-1:0] r_data_in,
  output logic [23:0]                 l_data_out,
  output logic [23:0]                 r_data_out,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int N     = num_of_filters;
  localparam int IDX_W = $clog2(N);
  localparam int ACC_W = AUDIO_W + GAIN_W + $clog2(N);

  eq_seq_state_t state, next_state;

  logic [GAIN_W-1:0]         pending_gain [N];
  logic signed [GAIN_W-1:0]  active_gain  [N];
  logic signed [AUDIO_W-1:0] l_sample     [N];
  logic signed [AUDIO_W-1:0] r_sample     [N];

  logic [IDX_W-1:0]          idx;
  logic                      ch;
  logic                      start;
  logic                      mac_en;
  logic                      last_mac;
  logic signed [AUDIO_W-1:0] mac_sample;
  logic signed [GAIN_W-1:0]  mac_gain;
  logic signed [ACC_W-1:0]   acc_l;
  logic signed [ACC_W-1:0]   acc_r;
  logic                      unused_low;

  // Scale back to audio units, then clamp to the 24-bit signed range.
  function automatic logic [AUDIO_W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> GAIN_FRAC;
    if (shifted > ACC_W'(AUDIO_MAX)) begin
      return AUDIO_MAX;
    end else if (shifted < ACC_W'(AUDIO_MIN)) begin
      return AUDIO_MIN;
    end
    return shifted[AUDIO_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    mac_en     = 1'b0;
    case (state)
      IDLE: begin
        if (sample_en) begin
          next_state = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        mac_en = 1'b1;
        if (last_mac) begin
          next_state = SAT;
        end
      end
      SAT:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign last_mac   = (idx == IDX_W'(N-1)) && ch;
  assign mac_sample = ch ? r_sample[idx] : l_sample[idx];
  assign mac_gain   = active_gain[idx];

  // Only the upper audio half of each band word is consumed.
  always_comb begin
    unused_low = 1'b0;
    for (int k = 0; k < N; k++) begin
      unused_low = unused_low ^ (^l_data_in[48*k +: 24]) ^ (^r_data_in[48*k +: 24]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        pending_gain[k] <= GAIN_UNITY;
        active_gain[k]  <= GAIN_UNITY;
        l_sample[k]     <= '0;
        r_sample[k]     <= '0;
      end
      idx        <= '0;
      ch         <= 1'b0;
      l_data_out <= '0;
      r_data_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (eq_wr && eq_wr_sel[k]) begin
          pending_gain[k] <= eq_gain;
        end
      end
      out_valid <= (state == SAT);
      overrun   <= sample_en && busy;
      // Active gains take the pending value as it stood before any same-cycle write.
      if (start) begin
        for (int k = 0; k < N; k++) begin
          active_gain[k] <= pending_gain[k];
          l_sample[k]    <= l_data_in[48*k+24 +: AUDIO_W];
          r_sample[k]    <= r_data_in[48*k+24 +: AUDIO_W];
        end
        idx <= '0;
        ch  <= 1'b0;
      end else if (mac_en) begin
        ch <= ~ch;
        if (ch) begin
          idx <= idx + 1'b1;
        end
      end
      if (state == SAT) begin
        l_data_out <= saturate(acc_l);
        r_data_out <= saturate(acc_r);
      end
    end
  end

  eq_mac #(
    .ACC_W(ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .en    (mac_en),
    .ch    (ch),
    .sample(mac_sample),
    .gain  (mac_gain),
    .acc_l (acc_l),
    .acc_r (acc_r)
  );

endmodule
